// File: rtl/pulse_sweep_engine.sv
// pulse_sweep_engine: coarse-to-fine search for the minimum pulse width (in
// clock cycles) that makes the circuit under characterization toggle its
// response lane. Each try is LEAD idle cycles, a pulse of pw cycles, OBS idle
// observation cycles and one UPDATE cycle.
// Optional feature macro: PSE_DIV5_EN selects a divide-by-5 step reduction
// instead of the STEP_SHIFT right shift.
// Handshake: start is accepted only while idle (busy low); done is a one-cycle
// strobe and found/result_width/tries hold until the next accepted start.
module pulse_sweep_engine #(
  parameter int W           = 16,
  parameter int CHANNELS    = 4,
  parameter int LEAD_CYCLES = 64,
  parameter int OBS_CYCLES  = 256,
  parameter int STEP_SHIFT  = 2,
  localparam int SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [SW-1:0]       chan_sel,
  input  logic                polarity,
  input  logic [W-1:0]        init_width,
  input  logic [W-1:0]        init_step,
  input  logic [CHANNELS-1:0] resp_in,
  output logic [CHANNELS-1:0] pulse_out,
  output logic                busy,
  output logic                done,
  output logic                found,
  output logic [W-1:0]        result_width,
  output logic [7:0]          tries,
  output logic [2:0]          state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEAD    = 3'd1,
    S_PULSE   = 3'd2,
    S_OBSERVE = 3'd3,
    S_UPDATE  = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [W-1:0] LEAD_LAST = W'(LEAD_CYCLES - 1);
  localparam logic [W-1:0] OBS_LAST  = W'(OBS_CYCLES - 1);

  state_t              state_q, state_n;
  logic [W-1:0]        cnt_q;
  logic [W-1:0]        pw_q, inc_q;
  logic [SW-1:0]       sel_q;
  logic                pol_q;
  logic                sync1_q, sync2_q, sync3_q;
  logic                det_q;
  logic                found_q;
  logic [W-1:0]        result_q;
  logic [7:0]          tries_q;

  logic [W-1:0]        inc_n;
  logic signed [W:0]   dec;
  logic [W-1:0]        pw_dec;
  logic [W:0]          sum;
  logic                upd_done;
  logic                pol_n;
  logic [CHANNELS-1:0] pulse_n;

  // Next-state logic plus the UPDATE-cycle arithmetic.
  always_comb begin
    state_n = state_q;
`ifdef PSE_DIV5_EN
    inc_n   = inc_q / W'(5);
`else
    inc_n   = inc_q >> STEP_SHIFT;
`endif
    dec      = $signed({1'b0, pw_q}) - $signed({1'b0, inc_q}) + $signed({1'b0, inc_n});
    pw_dec   = (dec[W] || dec[W-1:0] == '0) ? W'(1) : dec[W-1:0];
    sum      = {1'b0, pw_q} + {1'b0, inc_q};
    upd_done = det_q ? (inc_n == '0) : ((inc_q == '0) || sum[W]);
    case (state_q)
      S_IDLE:    if (start) state_n = S_LEAD;
      S_LEAD:    if (cnt_q == LEAD_LAST) state_n = S_PULSE;
      S_PULSE:   if (cnt_q == pw_q - W'(1)) state_n = S_OBSERVE;
      S_OBSERVE: if (cnt_q == OBS_LAST) state_n = S_UPDATE;
      S_UPDATE:  state_n = upd_done ? S_DONE : S_LEAD;
      S_DONE:    state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_n;
  end

  // Per-state cycle counter, restarted on every state change.
  always_ff @(posedge clk) begin
    if (rst || state_n != state_q || state_q == S_IDLE) cnt_q <= '0;
    else                                                cnt_q <= cnt_q + W'(1);
  end

  // Search registers: launch latching, try counting and width refinement.
  always_ff @(posedge clk) begin
    if (rst) begin
      pw_q <= '0; inc_q <= '0; sel_q <= '0; pol_q <= 1'b0;
      found_q <= 1'b0; result_q <= '0; tries_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          sel_q    <= chan_sel;
          pol_q    <= polarity;
          pw_q     <= (init_width == '0) ? W'(1) : init_width;
          inc_q    <= init_step;
          found_q  <= 1'b0;
          result_q <= '0;
          tries_q  <= '0;
        end
        S_PULSE: if (cnt_q == '0 && tries_q != 8'hFF) tries_q <= tries_q + 8'd1;
        S_UPDATE: begin
          if (det_q) begin
            result_q <= pw_q;
            found_q  <= 1'b1;
            pw_q     <= pw_dec;
            inc_q    <= inc_n;
          end else if (!upd_done) begin
            pw_q <= sum[W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Response synchronizer, edge detect and detection flag (masked in LEAD).
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0; sync2_q <= 1'b0; sync3_q <= 1'b0; det_q <= 1'b0;
    end else begin
      sync1_q <= resp_in[sel_q];
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      if (state_n == S_LEAD && state_q != S_LEAD)
        det_q <= 1'b0;
      else if ((state_q == S_PULSE || state_q == S_OBSERVE) && (sync2_q ^ sync3_q))
        det_q <= 1'b1;
    end
  end

  // Lane pattern for the next cycle, derived from the next state.
  always_comb begin
    pol_n   = (state_q == S_IDLE && start) ? polarity : pol_q;
    pulse_n = {CHANNELS{pol_n}};
    if (state_n == S_PULSE) pulse_n[sel_q] = ~pol_n;
  end

  // Registered stimulus lanes so pulse width is exact to the cycle.
  always_ff @(posedge clk) begin
    if (rst) pulse_out <= '0;
    else     pulse_out <= pulse_n;
  end

  assign busy         = (state_q == S_LEAD) || (state_q == S_PULSE) ||
                        (state_q == S_OBSERVE) || (state_q == S_UPDATE);
  assign done         = (state_q == S_DONE);
  assign found        = found_q;
  assign result_width = result_q;
  assign tries        = tries_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_pulse_sweep_engine.sv
// Bench for pulse_sweep_engine: directed searches against a threshold response
// model. Expected pulse widths and final results are queued at launch; monitors
// pop and compare as pulses finish and as done strobes appear.
module tb_pulse_sweep_engine;
  localparam int W    = 8;
  localparam int CH   = 4;
  localparam int LEAD = 16;
  localparam int OBS  = 32;

  logic          clk = 1'b0;
  logic          rst, start, polarity;
  logic [1:0]    chan_sel;
  logic [W-1:0]  init_width, init_step;
  logic [CH-1:0] resp_in;
  logic [CH-1:0] pulse_out;
  logic          busy, done, found;
  logic [W-1:0]  result_width;
  logic [7:0]    tries;
  logic [2:0]    state_dbg;

  pulse_sweep_engine #(.W(W), .CHANNELS(CH), .LEAD_CYCLES(LEAD),
                       .OBS_CYCLES(OBS), .STEP_SHIFT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .chan_sel(chan_sel),
    .polarity(polarity), .init_width(init_width), .init_step(init_step),
    .resp_in(resp_in), .pulse_out(pulse_out), .busy(busy), .done(done),
    .found(found), .result_width(result_width), .tries(tries),
    .state_dbg(state_dbg));

  // Clock and cycle counter.
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] width_q[$];
  logic [W+8:0] exp_q[$];

  bit   mon_en = 0, mon_want = 0, thresh_en = 0, mon_first = 1;
  int   thresh = 37;
  int   mon_lane = 0;
  logic mon_pol = 1'b0;
  int unsigned toggle_at = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W+8:0] pack(input logic f, input logic [W-1:0] r, input logic [7:0] t);
    return {f, r, t};
  endfunction

  // Pulse monitor and response model: measures each pulse on the watched lane,
  // checks width and try period, toggles the response when width >= thresh.
  initial begin
    bit in_p = 0;
    int w = 0, prev_w = 0;
    int unsigned prev_start = 0;
    resp_in = '0;
    forever begin
      @(negedge clk);
      if (toggle_at != 0 && cyc == toggle_at) resp_in[mon_lane] = ~resp_in[mon_lane];
      if (!mon_en) in_p = 0;
      else if (pulse_out[mon_lane] == ~mon_pol) begin
        if (!in_p) begin
          in_p = 1; w = 1;
          if (!mon_first) check("try_period", cyc - prev_start, LEAD + prev_w + OBS + 1);
          mon_first = 0;
          prev_start = cyc;
        end else w++;
      end else if (in_p) begin
        in_p = 0; prev_w = w;
        if (width_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pulse: width %0d with no expected width queued", w);
        end else check("try_width", w, width_q.pop_front());
        if (thresh_en && w >= thresh) resp_in[mon_lane] = ~resp_in[mon_lane];
      end
    end
  end

  // Result monitor: pops the expected result on each done strobe.
  initial begin
    logic [W+8:0] e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: done with no expected result queued");
        end else begin
          e = exp_q.pop_front();
          check("found", found, e[W+8]);
          check("result_width", result_width, e[W+7:8]);
          check("tries", tries, e[7:0]);
          check("widths_consumed", width_q.size(), 0);
          check("busy_at_done", busy, 0);
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic launch(input logic [1:0] ch, input logic pol, input logic [W-1:0] iw,
                        input logic [W-1:0] is);
    mon_en = 0;
    @(negedge clk);
    chan_sel = ch; polarity = pol; init_width = iw; init_step = is;
    mon_lane = ch; mon_pol = pol; mon_first = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    mon_en = mon_want;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1);
    if (!done) do_reset();
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_after_done", state_dbg, 0);
  endtask

  initial begin
    int bad, low, n;
    rst = 1'b1; start = 1'b1; chan_sel = '0; polarity = 1'b0;
    init_width = 8'd10; init_step = 8'd20;
    // Reset, with start held high at the same time.
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_pulse_out", pulse_out, 0);
    check("rst_done", done, 0);
    check("rst_found", found, 0);
    check("rst_result", result_width, 0);
    check("rst_tries", tries, 0);
    check("rst_state", state_dbg, 0);
    start = 1'b0; rst = 1'b0;
    @(negedge clk);

    // Basic search, threshold 37, with a start pulse while busy.
    mon_want = 1; thresh_en = 1;
`ifdef PSE_DIV5_EN
    width_q = '{8'd10, 8'd35, 8'd60, 8'd40, 8'd36, 8'd37};
    exp_q.push_back(pack(1'b1, 8'd37, 8'd6));
    launch(2'd0, 1'b0, 8'd10, 8'd25);
`else
    width_q = '{8'd10, 8'd30, 8'd50, 8'd35, 8'd40, 8'd36, 8'd37};
    exp_q.push_back(pack(1'b1, 8'd37, 8'd7));
    launch(2'd0, 1'b0, 8'd10, 8'd20);
`endif
    repeat (100) @(negedge clk);
    chan_sel = 2'd3; init_width = 8'd1; init_step = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(5000);

    // Overflow: 0xF0 + 0x10 does not fit in 8 bits, so a single try.
    thresh_en = 0;
    width_q.push_back(8'hF0);
    exp_q.push_back(pack(1'b0, 8'd0, 8'd1));
    launch(2'd1, 1'b0, 8'hF0, 8'h10);
    wait_done(2000);

    // Zero init_width is treated as one cycle.
    width_q.push_back(8'd1);
    exp_q.push_back(pack(1'b0, 8'd0, 8'd1));
    launch(2'd1, 1'b0, 8'd0, 8'd0);
    wait_done(500);

    // Polarity 1 on lane 2: exactly 5 low cycles, other lanes stay high.
    width_q.push_back(8'd5);
    exp_q.push_back(pack(1'b0, 8'd0, 8'd1));
    launch(2'd2, 1'b1, 8'd5, 8'd0);
    bad = 0; low = 0; n = 0;
    while (!done && n < 500) begin
      if (pulse_out[0] !== 1'b1 || pulse_out[1] !== 1'b1 || pulse_out[3] !== 1'b1) bad++;
      if (pulse_out[2] === 1'b0) low++;
      @(negedge clk);
      n++;
    end
    check("other_lanes_idle", bad, 0);
    check("lane2_low_cycles", low, 5);
    wait_done(10);

    // Lead masking: response toggles only during LEAD.
    width_q.push_back(8'd3);
    exp_q.push_back(pack(1'b0, 8'd0, 8'd1));
    launch(2'd0, 1'b0, 8'd3, 8'd0);
    toggle_at = cyc + 3;
    wait_done(500);
    toggle_at = 0;

    // Reset during PULSE: lanes and results clear, no done strobe.
    mon_want = 0;
    launch(2'd1, 1'b0, 8'd20, 8'd0);
    n = 0;
    while (pulse_out[1] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reached_pulse", pulse_out[1], 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_pulse_out", pulse_out, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_tries", tries, 0);
    check("midrst_state", state_dbg, 0);
    repeat (40) @(negedge clk);
    check("midrst_still_idle", busy, 0);

    check("exp_q_empty", exp_q.size(), 0);
    check("width_q_empty", width_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
